// File: rtl/series_eval_ctrl_pkg.sv
// series_eval_ctrl_pkg: shared Q6.10 format constants, FSM states and saturating clamp
package series_eval_ctrl_pkg;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 10;
    localparam logic signed [DATA_W-1:0] ONE = 16'sd1024;
    localparam logic signed [2*DATA_W-1:0] SAT_MAX = (2**(DATA_W-1)) - 1;
    localparam logic signed [2*DATA_W-1:0] SAT_MIN = -(2**(DATA_W-1));

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [2*DATA_W-1:0] v);
        return (v > SAT_MAX) ? DATA_W'(SAT_MAX) : (v < SAT_MIN) ? DATA_W'(SAT_MIN) : v[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/series_eval_ctrl_sat_mac.sv
// series_eval_ctrl_sat_mac: y = sat(sat(floor(acc*x / 2**FRAC_W)) + coeff), purely combinational
module series_eval_ctrl_sat_mac #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 10
) (
    input  logic signed [DATA_W-1:0] acc,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] coeff,
    output logic signed [DATA_W-1:0] y
);
    import series_eval_ctrl_pkg::*;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W-1:0] shifted;
    logic signed [DATA_W-1:0]   scaled;
    logic signed [DATA_W:0]     sum;

    always_comb begin
        prod    = acc * x;
        shifted = prod >>> FRAC_W;
        scaled  = sat(shifted);
        sum     = scaled + coeff;
        y       = sat((2*DATA_W)'(sum));
    end
endmodule

// File: rtl/series_eval_ctrl.sv
// series_eval_ctrl: Horner evaluation of a polynomial held in an external combinational ROM
module series_eval_ctrl #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 10,
    parameter int N_TERMS = 7,
    parameter int SEL_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] x_in,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] result,
    output logic [SEL_W-1:0]         rom_select,
    input  logic signed [DATA_W-1:0] rom_coeff
);
    import series_eval_ctrl_pkg::*;

    state_t                    state_q, state_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic signed [DATA_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0]  x_q, x_d;
    logic signed [DATA_W-1:0]  result_q, result_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic signed [DATA_W-1:0]  mac_y;

    series_eval_ctrl_sat_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mac (
        .acc  (acc_q),
        .x    (x_q),
        .coeff(rom_coeff),
        .y    (mac_y)
    );

    // result is loaded on the last ITER step so it is already valid while done is high
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        acc_d    = acc_q;
        x_d      = x_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: if (start) begin
                x_d     = x_in;
                sel_d   = SEL_W'(N_TERMS - 1);
                state_d = LOAD;
            end
            LOAD: begin
                acc_d   = rom_coeff;
                sel_d   = sel_q - 1'b1;
                state_d = ITER;
            end
            ITER: begin
                acc_d = mac_y;
                if (sel_q == '0) begin
                    result_d = mac_y;
                    state_d  = DONE;
                end else begin
                    sel_d = sel_q - 1'b1;
                end
            end
            DONE: state_d = IDLE;
        endcase
        busy_d = (state_d == LOAD) || (state_d == ITER);
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign rom_select = sel_q;
endmodule

// File: tb/tb_series_eval_ctrl.sv
// tb_series_eval_ctrl: directed vectors with a scoreboard queue checked by a done-driven monitor
module tb_series_eval_ctrl;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic signed [15:0] x_in = '0;
    logic               busy, done;
    logic signed [15:0] result;
    logic [2:0]         rom_select;
    logic signed [15:0] rom_coeff;

    logic signed [15:0] rom [7] = '{-16'sd1024, -16'sd170, -16'sd68, -16'sd36, -16'sd23, -16'sd16, -16'sd11};
    assign rom_coeff = (rom_select < 3'd7) ? rom[rom_select] : 16'sd0;

    series_eval_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
        .busy(busy), .done(done), .result(result),
        .rom_select(rom_select), .rom_coeff(rom_coeff)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] res;
        int                 cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cycle %0d result %0d required no done", cyc, result);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (result !== e.res) begin
                    errors++;
                    $display("FAIL result got %0d required %0d", result, e.res);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL done_cycle got %0d required %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic check_idle_outputs(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'sd0 || rom_select !== 3'd0) begin
            errors++;
            $display("FAIL %s busy=%b done=%b result=%0d sel=%0d required all 0", name, busy, done, result, rom_select);
        end
    endtask

    // One evaluation; optionally pokes start/x_in while busy to show they are ignored
    task automatic run(input logic signed [15:0] x, input logic signed [15:0] exp_res, input bit poke);
        int k;
        @(negedge clk);
        start = 1'b1;
        x_in  = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = cyc;
        q.push_back('{exp_res, k + 7});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== (i < 7)) begin
                errors++;
                $display("FAIL busy x=%0d step %0d got %b required %b", x, i, busy, (i < 7));
            end
            if (poke && i == 3) begin
                start = 1'b1;
                x_in  = 16'sd512;
            end
            if (poke && i == 4) start = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        int k;
        #2;
        check_idle_outputs("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_outputs("after_reset_release");

        run(16'sd0,     -16'sd1024,  1'b0);
        run(16'sd1024,  -16'sd1348,  1'b0);
        run(-16'sd1024, -16'sd904,   1'b0);
        run(16'sd512,   -16'sd1133,  1'b0);
        run(16'sd32767, -16'sd32768, 1'b0);
        run(16'sd1024,  -16'sd1348,  1'b1);

        // start held high: accepted every 9 cycles, ignored in DONE and while busy
        @(negedge clk);
        start = 1'b1;
        x_in  = 16'sd0;
        @(posedge clk);
        #1;
        k = cyc;
        q.push_back('{-16'sd1024, k + 7});
        q.push_back('{-16'sd1024, k + 16});
        q.push_back('{-16'sd1024, k + 25});
        repeat (18) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(negedge clk);

        // async reset mid-evaluation aborts without a done pulse
        @(negedge clk);
        start = 1'b1;
        x_in  = 16'sd1024;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_op_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_idle_outputs("no_resume_after_reset");

        run(16'sd0, -16'sd1024, 1'b0);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain %0d expected results never produced, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
